// File: rtl/prewish5k_mask_arbiter.sv
// prewish5k_mask_arbiter
// Two-requester round-robin arbiter in front of the mentor's single mask-load
// port. Each grant produces a one-cycle load strobe with an acknowledge to the
// winner. A programmable quiet gap then follows before the next grant.
module prewish5k_mask_arbiter #(
    parameter int DATA_BITS  = 8,
    parameter int GAP_CYCLES = 8,
    parameter int GAP_BITS   = 4,
    parameter int ALIVE_BITS = 22
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 REQ0_I,
    input  logic [DATA_BITS-1:0] DAT0_I,
    output logic                 ACK0_O,
    input  logic                 REQ1_I,
    input  logic [DATA_BITS-1:0] DAT1_I,
    output logic                 ACK1_O,
    output logic                 STB_O,
    output logic [DATA_BITS-1:0] DAT_O,
    output logic                 o_grant,
    output logic                 o_busy,
    output logic                 o_alive
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    localparam logic [GAP_BITS-1:0] GAP_LOAD = GAP_BITS'(GAP_CYCLES);
    localparam bit                  GAP_NONE = (GAP_CYCLES == 0);

    state_t                 state_r;
    state_t                 state_s;
    logic [GAP_BITS-1:0]    gap_cnt_r;
    logic [GAP_BITS-1:0]    gap_cnt_s;
    logic                   stb_r;
    logic                   stb_s;
    logic                   ack0_r;
    logic                   ack0_s;
    logic                   ack1_r;
    logic                   ack1_s;
    logic                   grant_r;
    logic                   grant_s;
    logic                   busy_r;
    logic [DATA_BITS-1:0]   dat_r;
    logic [DATA_BITS-1:0]   dat_s;
    logic [ALIVE_BITS-1:0]  alive_r;
    logic                   any_req_s;
    logic                   pick_s;

    // Round-robin pick: a tie goes to the requester that did not win last time.
    always_comb begin
        any_req_s = REQ0_I | REQ1_I;
        if (REQ0_I && REQ1_I) begin
            pick_s = ~grant_r;
        end else if (REQ1_I) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: IDLE -> STROBE on any request, then GAP (or IDLE when no gap).
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_s = ST_STROBE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_STROBE: begin
                if (GAP_NONE) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_GAP;
                end
            end
            ST_GAP: begin
                // Counter at 1 (or an impossible 0) ends the gap.
                if (gap_cnt_r <= GAP_BITS'(1)) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_GAP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output/datapath next values; strobe and ack are only raised on an IDLE grant.
    always_comb begin
        stb_s     = 1'b0;
        ack0_s    = 1'b0;
        ack1_s    = 1'b0;
        dat_s     = dat_r;
        grant_s   = grant_r;
        gap_cnt_s = gap_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    stb_s   = 1'b1;
                    ack0_s  = ~pick_s;
                    ack1_s  = pick_s;
                    dat_s   = pick_s ? DAT1_I : DAT0_I;
                    grant_s = pick_s;
                end else begin
                    stb_s = 1'b0;
                end
            end
            ST_STROBE: begin
                gap_cnt_s = GAP_LOAD;
            end
            ST_GAP: begin
                // Saturate at zero so the counter never wraps.
                if (gap_cnt_r != {GAP_BITS{1'b0}}) begin
                    gap_cnt_s = gap_cnt_r - GAP_BITS'(1);
                end else begin
                    gap_cnt_s = gap_cnt_r;
                end
            end
            default: begin
                gap_cnt_s = {GAP_BITS{1'b0}};
            end
        endcase
    end

    // Registered outputs; reset drops any strobe/ack in flight.
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            stb_r     <= 1'b0;
            ack0_r    <= 1'b0;
            ack1_r    <= 1'b0;
            dat_r     <= {DATA_BITS{1'b0}};
            grant_r   <= 1'b1;
            gap_cnt_r <= {GAP_BITS{1'b0}};
            busy_r    <= 1'b0;
        end else begin
            stb_r     <= stb_s;
            ack0_r    <= ack0_s;
            ack1_r    <= ack1_s;
            dat_r     <= dat_s;
            grant_r   <= grant_s;
            gap_cnt_r <= gap_cnt_s;
            busy_r    <= (state_s != ST_IDLE);
        end
    end

    // Free-running alive counter, wraps naturally.
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            alive_r <= {ALIVE_BITS{1'b0}};
        end else begin
            alive_r <= alive_r + ALIVE_BITS'(1);
        end
    end

    assign STB_O   = stb_r;
    assign ACK0_O  = ack0_r;
    assign ACK1_O  = ack1_r;
    assign DAT_O   = dat_r;
    assign o_grant = grant_r;
    assign o_busy  = busy_r;
    assign o_alive = alive_r[ALIVE_BITS-1];

endmodule

// File: tb/tb_prewish5k_mask_arbiter.sv
// Bench for prewish5k_mask_arbiter: instance 0 uses an 8-cycle gap, instance 1
// uses no gap. Directed scenarios plus a randomized run against a model that
// works from grant times ("next allowed grant edge") rather than FSM states.
module tb_prewish5k_mask_arbiter;

    localparam int DB = 8;
    localparam int AB = 22;

    logic          clk = 1'b0;
    logic          rst  [2];
    logic          req0 [2];
    logic          req1 [2];
    logic [DB-1:0] d0   [2];
    logic [DB-1:0] d1   [2];
    logic          ack0 [2];
    logic          ack1 [2];
    logic          stb  [2];
    logic [DB-1:0] dat  [2];
    logic          grant[2];
    logic          busy [2];
    logic          alive[2];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // reference model state
    int          gapv [2] = '{8, 0};
    int          m_next_ok[2];
    bit          m_stb[2], m_ack0[2], m_ack1[2], m_grant[2], m_busy[2];
    logic [DB-1:0] m_dat[2];
    int unsigned m_alive[2];

    always #5 clk = ~clk;

    prewish5k_mask_arbiter #(.DATA_BITS(DB), .GAP_CYCLES(8), .GAP_BITS(4), .ALIVE_BITS(AB)) dut_g8 (
        .CLK_I(clk), .RST_I(rst[0]),
        .REQ0_I(req0[0]), .DAT0_I(d0[0]), .ACK0_O(ack0[0]),
        .REQ1_I(req1[0]), .DAT1_I(d1[0]), .ACK1_O(ack1[0]),
        .STB_O(stb[0]), .DAT_O(dat[0]),
        .o_grant(grant[0]), .o_busy(busy[0]), .o_alive(alive[0])
    );

    prewish5k_mask_arbiter #(.DATA_BITS(DB), .GAP_CYCLES(0), .GAP_BITS(4), .ALIVE_BITS(AB)) dut_g0 (
        .CLK_I(clk), .RST_I(rst[1]),
        .REQ0_I(req0[1]), .DAT0_I(d0[1]), .ACK0_O(ack0[1]),
        .REQ1_I(req1[1]), .DAT1_I(d1[1]), .ACK1_O(ack1[1]),
        .STB_O(stb[1]), .DAT_O(dat[1]),
        .o_grant(grant[1]), .o_busy(busy[1]), .o_alive(alive[1])
    );

    // Advance one rising edge, then update the model from the inputs seen at that edge.
    task automatic tick();
        bit n;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!rst[i]) begin
                m_stb[i] = 0; m_ack0[i] = 0; m_ack1[i] = 0;
                m_dat[i] = '0; m_grant[i] = 1; m_busy[i] = 0;
                m_alive[i] = 0; m_next_ok[i] = cyc + 1;
            end else begin
                m_alive[i] = (m_alive[i] + 1) % (32'd1 << AB);
                m_stb[i] = 0; m_ack0[i] = 0; m_ack1[i] = 0;
                if (cyc >= m_next_ok[i] && (req0[i] || req1[i])) begin
                    n = (req0[i] && req1[i]) ? !m_grant[i] : req1[i];
                    m_stb[i] = 1;
                    if (n) m_ack1[i] = 1; else m_ack0[i] = 1;
                    m_dat[i] = n ? d1[i] : d0[i];
                    m_grant[i] = n;
                    m_next_ok[i] = cyc + gapv[i] + 2;
                end
                m_busy[i] = (cyc < m_next_ok[i] - 1);
            end
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            rst[i] = 0; req0[i] = 0; req1[i] = 0; d0[i] = '0; d1[i] = '0;
        end
        tick();
        tick();
        rst[0] = 1; rst[1] = 1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (stb[i] !== 1'b0 || ack0[i] !== 1'b0 || ack1[i] !== 1'b0 || dat[i] !== 8'h00 ||
                grant[i] !== 1'b1 || busy[i] !== 1'b0 || alive[i] !== 1'b0)
                $display("FAIL reset_state inst%0d: stb=%b ack0=%b ack1=%b dat=%h grant=%b busy=%b alive=%b, want 0 0 0 00 1 0 0",
                         i, stb[i], ack0[i], ack1[i], dat[i], grant[i], busy[i], alive[i]);
        end
        errors += 0;
        for (int i = 0; i < 2; i++) begin
            if (stb[i] !== 1'b0 || dat[i] !== 8'h00 || grant[i] !== 1'b1 || busy[i] !== 1'b0 ||
                ack0[i] !== 1'b0 || ack1[i] !== 1'b0 || alive[i] !== 1'b0) errors++;
        end
    endtask

    task automatic test_single_req();
        do_reset();
        req0[0] = 1; d0[0] = 8'hA5;
        tick();
        checks++;
        if (stb[0] !== 1'b1 || ack0[0] !== 1'b1 || ack1[0] !== 1'b0 || dat[0] !== 8'hA5 || grant[0] !== 1'b0 || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: stb=%b ack0=%b ack1=%b dat=%h grant=%b busy=%b, want 1 1 0 a5 0 1",
                     stb[0], ack0[0], ack1[0], dat[0], grant[0], busy[0]);
        end
        req0[0] = 0;
        tick();
        checks++;
        if (stb[0] !== 1'b0 || ack0[0] !== 1'b0 || ack1[0] !== 1'b0 || dat[0] !== 8'hA5) begin
            errors++;
            $display("FAIL single_oneshot: stb=%b ack0=%b ack1=%b dat=%h, want 0 0 0 a5", stb[0], ack0[0], ack1[0], dat[0]);
        end
    endtask

    task automatic test_round_robin();
        int          rises[$];
        logic [DB-1:0] loads[$];
        logic [DB-1:0] want;
        do_reset();
        req0[0] = 1; req1[0] = 1; d0[0] = 8'h0F; d1[0] = 8'hF0;
        for (int t = 0; t < 45 && rises.size() < 4; t++) begin
            tick();
            if (stb[0] === 1'b1) begin
                rises.push_back(cyc);
                loads.push_back(dat[0]);
            end
        end
        checks++;
        if (rises.size() != 4) begin
            errors++;
            $display("FAIL rr_count: got %0d loads, want 4", rises.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                want = (k % 2 == 0) ? 8'h0F : 8'hF0;
                checks++;
                if (loads[k] !== want) begin
                    errors++;
                    $display("FAIL rr_order load%0d: dat=%h want %h", k, loads[k], want);
                end
                if (k > 0) begin
                    checks++;
                    if (rises[k] - rises[k-1] != 10) begin
                        errors++;
                        $display("FAIL rr_spacing load%0d: %0d cycles want 10", k, rises[k] - rises[k-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_gap_hold();
        do_reset();
        req0[0] = 1; d0[0] = 8'h11;
        tick();
        req0[0] = 0;
        tick();
        req1[0] = 1; d1[0] = 8'h3C;
        for (int j = 3; j <= 11; j++) begin
            tick();
            checks++;
            if (j < 11) begin
                if (stb[0] !== 1'b0 || ack1[0] !== 1'b0 || dat[0] !== 8'h11) begin
                    errors++;
                    $display("FAIL gap_hold tick%0d: stb=%b ack1=%b dat=%h, want 0 0 11", j, stb[0], ack1[0], dat[0]);
                end
            end else begin
                if (stb[0] !== 1'b1 || ack1[0] !== 1'b1 || dat[0] !== 8'h3C) begin
                    errors++;
                    $display("FAIL gap_release: stb=%b ack1=%b dat=%h, want 1 1 3c", stb[0], ack1[0], dat[0]);
                end
            end
        end
        req1[0] = 0;
    endtask

    task automatic test_gap_zero();
        bit          odd;
        bit          who;
        do_reset();
        req0[1] = 1; req1[1] = 1; d0[1] = 8'h0F; d1[1] = 8'hF0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            odd = (j % 2 == 1);
            who = ((j - 1) / 2) % 2;
            checks++;
            if (stb[1] !== odd || busy[1] !== odd) begin
                errors++;
                $display("FAIL gap0_pulse tick%0d: stb=%b busy=%b, want %b %b", j, stb[1], busy[1], odd, odd);
            end
            if (odd) begin
                checks++;
                if (grant[1] !== who || ack0[1] !== !who || ack1[1] !== who || dat[1] !== (who ? 8'hF0 : 8'h0F)) begin
                    errors++;
                    $display("FAIL gap0_alt tick%0d: grant=%b ack0=%b ack1=%b dat=%h, want grant %b", j, grant[1], ack0[1], ack1[1], dat[1], who);
                end
            end
        end
    endtask

    task automatic test_reset_strobe();
        do_reset();
        req0[0] = 1; req1[0] = 1; d0[0] = 8'h5A; d1[0] = 8'h77;
        tick();
        rst[0] = 0;
        tick();
        checks++;
        if (stb[0] !== 1'b0 || ack0[0] !== 1'b0 || ack1[0] !== 1'b0 || dat[0] !== 8'h00 || grant[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_midstrobe: stb=%b ack0=%b ack1=%b dat=%h grant=%b busy=%b, want 0 0 0 00 1 0",
                     stb[0], ack0[0], ack1[0], dat[0], grant[0], busy[0]);
        end
        rst[0] = 1; req0[0] = 0;
        tick();
        checks++;
        if (stb[0] !== 1'b1 || ack1[0] !== 1'b1 || ack0[0] !== 1'b0 || grant[0] !== 1'b1 || dat[0] !== 8'h77) begin
            errors++;
            $display("FAIL reset_regrant: stb=%b ack1=%b ack0=%b grant=%b dat=%h, want 1 1 0 1 77",
                     stb[0], ack1[0], ack0[0], grant[0], dat[0]);
        end
        req1[0] = 0;
    endtask

    task automatic test_dat_sample();
        logic [DB-1:0] v;
        logic [DB-1:0] last;
        do_reset();
        req0[0] = 1;
        last = 8'h00;
        for (int j = 1; j <= 25; j++) begin
            v = DB'($urandom);
            d0[0] = v;
            tick();
            checks++;
            if (j == 1 || j == 11 || j == 21) begin
                if (stb[0] !== 1'b1 || dat[0] !== v) begin
                    errors++;
                    $display("FAIL dat_sample tick%0d: stb=%b dat=%h, want 1 %h", j, stb[0], dat[0], v);
                end
                last = v;
            end else begin
                if (stb[0] !== 1'b0 || dat[0] !== last) begin
                    errors++;
                    $display("FAIL dat_hold tick%0d: stb=%b dat=%h, want 0 %h", j, stb[0], dat[0], last);
                end
            end
        end
        req0[0] = 0;
    endtask

    task automatic test_random();
        bit want_alive;
        do_reset();
        for (int t = 0; t < 800; t++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                want_alive = m_alive[i][AB-1];
                checks++;
                if (stb[i] !== m_stb[i] || ack0[i] !== m_ack0[i] || ack1[i] !== m_ack1[i] || dat[i] !== m_dat[i] ||
                    grant[i] !== m_grant[i] || busy[i] !== m_busy[i] || alive[i] !== want_alive) begin
                    errors++;
                    $display("FAIL random inst%0d cyc%0d: stb=%b ack0=%b ack1=%b dat=%h grant=%b busy=%b alive=%b, want %b %b %b %h %b %b %b",
                             i, cyc, stb[i], ack0[i], ack1[i], dat[i], grant[i], busy[i], alive[i],
                             m_stb[i], m_ack0[i], m_ack1[i], m_dat[i], m_grant[i], m_busy[i], want_alive);
                end
                // requesters: usually drop on ack, sometimes re-request
                if (ack0[i] === 1'b1 && $urandom_range(0, 4) != 0) req0[i] = 0;
                else if (!req0[i]) req0[i] = ($urandom_range(0, 3) == 0);
                if (ack1[i] === 1'b1 && $urandom_range(0, 4) != 0) req1[i] = 0;
                else if (!req1[i]) req1[i] = ($urandom_range(0, 3) == 0);
                d0[i] = DB'($urandom);
                d1[i] = DB'($urandom);
                rst[i] = ($urandom_range(0, 59) != 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_req();
        test_round_robin();
        test_gap_hold();
        test_gap_zero();
        test_reset_strobe();
        test_dat_sample();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prewish5k_mask_arbiter.md
Name: prewish5k_mask_arbiter

Overview:
- Shares the mentor's single mask-load port (STB_I/DAT_I) between two independent mask sources: requester 0 (the button/DIP loader) and requester 1 (a future auto-pattern sequencer).
- Uses round-robin arbitration and a one-cycle load strobe to the mentor.
- Enforces a programmable quiet gap between consecutive loads so the mentor and blinky can settle.
- Sits between the controller's request logic and the mentor instance.

Parameters:
- DATA_BITS, 8: width of mask data on all data ports.
- GAP_CYCLES, 8: number of GAP-state cycles after every load strobe; 0 is legal.
- GAP_BITS, 4: width of the gap counter; must satisfy 2^GAP_BITS > GAP_CYCLES.
- ALIVE_BITS, 22: width of the free-running alive counter.

Ports:
- CLK_I  in  1  system clock; all logic on rising edge.
- RST_I  in  1  reset; synchronous, active-low (0 = reset).
- REQ0_I  in  1  requester 0 load request; level, held until ACK0_O seen.
- DAT0_I  in  DATA_BITS  requester 0 mask; stable while REQ0_I high.
- ACK0_O  out  1  one-cycle grant/acknowledge to requester 0.
- REQ1_I  in  1  requester 1 load request.
- DAT1_I  in  DATA_BITS  requester 1 mask.
- ACK1_O  out  1  one-cycle grant/acknowledge to requester 1.
- STB_O  out  1  load strobe to mentor STB_I; one cycle per load.
- DAT_O  out  DATA_BITS  mask to mentor DAT_I.
- o_grant  out  1  index of the last granted requester.
- o_busy  out  1  high whenever the state is not IDLE.
- o_alive  out  1  MSB of the alive counter.

Behaviour:
- Reset (RST_I==0 at a rising edge): state=IDLE, STB_O=0, DAT_O=0, ACK0_O=0, ACK1_O=0, o_grant=1 (so requester 0 wins the first tie), gap counter=0, o_busy=0. The alive counter also resets to 0.
- All outputs are registered. o_busy is registered and equals (next state != IDLE).
- States are IDLE, STROBE and GAP.
- IDLE, evaluated at each edge:
  - No request: stay in IDLE.
  - Exactly one REQn high: grant n.
  - Both high: grant the requester that is not o_grant (round-robin).
  - On grant at edge k: DAT_O<=DATn_I, STB_O<=1, ACKn_O<=1, o_grant<=n, state<=STROBE.
- STROBE, one cycle (STB_O and ACKn high during cycle k):
  - At the next edge: STB_O<=0, ACK<=0, gap counter<=GAP_CYCLES.
  - Go to state GAP, or straight to IDLE if GAP_CYCLES==0.
- GAP:
  - The counter decrements each edge.
  - When the counter is 1 at an edge, state<=IDLE.
  - The counter is never negative and never wraps.
  - REQs are ignored in GAP; no ACK is issued.
- Timing:
  - Minimum spacing from one STB_O rise to the next is GAP_CYCLES+2 cycles.
  - Grant latency from REQ high in IDLE to STB_O/ACK high is 1 edge.
- Requester contract: drop REQ at the edge it samples ACK high. A REQ still high in IDLE after its ACK is a new request (it re-loads the same data).
- DAT_O holds its last loaded value between strobes; it changes only on a grant edge.
- DATn_I is sampled only on the grant edge; changes on other cycles have no effect.
- Simultaneous request arrival while in GAP: both wait; on return to IDLE, round-robin decides.
- Starvation bound: with both requesters continuously requesting, grants strictly alternate 0,1,0,1…
- Reset mid-operation (any state): at the next edge, reset values are taken. A STB_O or ACK in flight is dropped to 0 and no partial load is issued. Pending REQs are served from the first IDLE edge with RST_I==1.
- Alive counter: increments every non-reset edge and wraps modulo 2^ALIVE_BITS.

Test Plan:
- Release reset, REQ0=1 with DAT0=8'hA5 → STB_O and ACK0_O high exactly 1 cycle at the next edge, DAT_O=8'hA5, o_grant=0, ACK1_O stays 0.
- REQ0 and REQ1 both held high (DAT0=8'h0F, DAT1=8'hF0) starting from reset → loads in order 0F, F0, 0F, F0. STB_O rises are spaced exactly GAP_CYCLES+2=10 cycles apart.
- REQ1=1, DAT1=8'h3C raised during GAP after a load of 8'h11 → no STB_O until the gap expires, then DAT_O=8'h3C. DAT_O holds 8'h11 throughout the gap.
- Build with GAP_CYCLES=0 and both REQs held → STB_O pulses every 2 cycles, alternating requesters, and o_busy pulses high only during the strobe cycle.
- RST_I=0 driven on the STROBE cycle → STB_O=0, ACKs=0, DAT_O=0, o_grant=1 at the next edge. After release with REQ1 held, the first grant goes to requester 1.
- DAT0_I toggled every cycle while REQ0 is held between grants → DAT_O equals the DAT0_I value present at the grant edge only.
